// File: rtl/regfile_rename_pkg.sv
// Shared types and build options for the register file / rename block.
// Build option: define REGFILE_COMMIT_BYPASS_EN to forward a same-cycle
// commit into the operand queries.
package regfile_rename_pkg;

  // Default widths shared with the ROB and dispatch blocks.
  localparam int DATA_BUS_W = 32;  // DataBus
  localparam int REG_AW     = 5;   // RegBus
  localparam int ROB_BUS_W  = 4;   // ROBBus

  typedef logic [DATA_BUS_W-1:0] data_bus_t;
  typedef logic [REG_AW-1:0]     reg_bus_t;
  typedef logic [ROB_BUS_W-1:0]  rob_bus_t;

`ifdef REGFILE_COMMIT_BYPASS_EN
  // A commit in flight is visible to queries in the same cycle.
  localparam bit COMMIT_BYPASS_EN = 1'b1;
`else
  // Queries see a commit only after it has been written.
  localparam bit COMMIT_BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_rename_if.sv
// Dispatch / ROB-commit bus of the register file: two operand queries,
// one rename request and one commit write.
interface regfile_rename_if
  import regfile_rename_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W,
  parameter int ROB_W  = ROB_BUS_W
) ();

  // Operand query 1
  logic              rs1_S;
  reg_bus_t          rs1;
  logic              rs1_busy;
  logic [ROB_W-1:0]  rs1_Reorder;
  logic [DATA_W-1:0] rs1_value;

  // Operand query 2
  logic              rs2_S;
  reg_bus_t          rs2;
  logic              rs2_busy;
  logic [ROB_W-1:0]  rs2_Reorder;
  logic [DATA_W-1:0] rs2_value;

  // Rename request from dispatch
  logic              Dispatch_S;
  reg_bus_t          Dispatch_rd;
  logic [ROB_W-1:0]  Dispatch_Reorder;

  // Commit write from the ROB
  logic              Reg_write_S;
  reg_bus_t          Reg_rd;
  logic [ROB_W-1:0]  Reg_Reorder;
  logic [DATA_W-1:0] Reg_result;

  // Dispatch/ROB side
  modport master (
    output rs1_S, rs1, rs2_S, rs2,
    output Dispatch_S, Dispatch_rd, Dispatch_Reorder,
    output Reg_write_S, Reg_rd, Reg_Reorder, Reg_result,
    input  rs1_busy, rs1_Reorder, rs1_value,
    input  rs2_busy, rs2_Reorder, rs2_value
  );

  // Register file side
  modport slave (
    input  rs1_S, rs1, rs2_S, rs2,
    input  Dispatch_S, Dispatch_rd, Dispatch_Reorder,
    input  Reg_write_S, Reg_rd, Reg_Reorder, Reg_result,
    output rs1_busy, rs1_Reorder, rs1_value,
    output rs2_busy, rs2_Reorder, rs2_value
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational operand query port: selects busy/tag/value for an
// index and, when REGFILE_COMMIT_BYPASS_EN is defined, forwards a matching
// same-cycle commit.
module regfile_read_port
  import regfile_rename_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = DATA_BUS_W,
  parameter int ROB_W   = ROB_BUS_W
) (
  input  logic              rdy,
  input  logic              query_s,
  input  reg_bus_t          query_idx,
  input  logic [REG_NUM-1:0] busy_vec,
  input  logic [ROB_W-1:0]  tag_arr   [REG_NUM],
  input  logic [DATA_W-1:0] value_arr [REG_NUM],
  input  logic              commit_s,
  input  reg_bus_t          commit_rd,
  input  logic [ROB_W-1:0]  commit_tag,
  input  logic [DATA_W-1:0] commit_result,
  output logic              busy,
  output logic [ROB_W-1:0]  reorder,
  output logic [DATA_W-1:0] value
);

  logic bypass_hit;

  // A commit only forwards when it will actually retire the pending rename
  // this cycle (clock enabled, same register, still busy, same tag).
  always_comb begin
    bypass_hit = COMMIT_BYPASS_EN && rdy && commit_s &&
                 (commit_rd == query_idx) && (query_idx != '0) &&
                 busy_vec[query_idx] && (tag_arr[query_idx] == commit_tag);
  end

  // Query mux; an invalid query or x0 reads as not-busy zero.
  always_comb begin
    busy    = 1'b0;
    reorder = '0;
    value   = '0;
    if (query_s) begin
      reorder = tag_arr[query_idx];
      if (query_idx != '0) begin
        busy  = busy_vec[query_idx];
        value = value_arr[query_idx];
        if (bypass_hit) begin
          busy  = 1'b0;
          value = commit_result;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags. Commit writes
// come from the ROB, rename requests from dispatch, and a ROB flush (clr)
// drops every outstanding rename.
// Build option: REGFILE_COMMIT_BYPASS_EN (see regfile_read_port).
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = DATA_BUS_W,
  parameter int ROB_W   = ROB_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  regfile_rename_if.slave   bus
);

  logic [REG_NUM-1:0] busy_vec;
  logic [ROB_W-1:0]   tag_arr   [REG_NUM];
  logic [DATA_W-1:0]  value_arr [REG_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 is hardwired zero and never renamed.
        assign busy_vec[gi]  = 1'b0;
        assign tag_arr[gi]   = '0;
        assign value_arr[gi] = '0;
      end else begin : g_live
        logic              busy_reg;
        logic [ROB_W-1:0]  tag_reg;
        logic [DATA_W-1:0] value_reg;
        logic              commit_hit;
        logic              rename_hit;

        assign commit_hit = bus.Reg_write_S && (bus.Reg_rd == REG_AW'(gi));
        assign rename_hit = bus.Dispatch_S && (bus.Dispatch_rd == REG_AW'(gi));

        // Commit writes the value; flush beats rename, rename beats the
        // busy-clear, and only the matching tag may clear busy.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            busy_reg  <= 1'b0;
            tag_reg   <= '0;
            value_reg <= '0;
          end else if (rdy) begin
            if (commit_hit) begin
              value_reg <= bus.Reg_result;
            end
            if (clr) begin
              busy_reg <= 1'b0;
            end else if (rename_hit) begin
              busy_reg <= 1'b1;
              tag_reg  <= bus.Dispatch_Reorder;
            end else if (commit_hit && busy_reg && (tag_reg == bus.Reg_Reorder)) begin
              busy_reg <= 1'b0;
            end
          end
        end

        assign busy_vec[gi]  = busy_reg;
        assign tag_arr[gi]   = tag_reg;
        assign value_arr[gi] = value_reg;
      end
    end
  endgenerate

  regfile_read_port #(
    .REG_NUM (REG_NUM),
    .DATA_W  (DATA_W),
    .ROB_W   (ROB_W)
  ) u_rs1_port (
    .rdy           (rdy),
    .query_s       (bus.rs1_S),
    .query_idx     (bus.rs1),
    .busy_vec      (busy_vec),
    .tag_arr       (tag_arr),
    .value_arr     (value_arr),
    .commit_s      (bus.Reg_write_S),
    .commit_rd     (bus.Reg_rd),
    .commit_tag    (bus.Reg_Reorder),
    .commit_result (bus.Reg_result),
    .busy          (bus.rs1_busy),
    .reorder       (bus.rs1_Reorder),
    .value         (bus.rs1_value)
  );

  regfile_read_port #(
    .REG_NUM (REG_NUM),
    .DATA_W  (DATA_W),
    .ROB_W   (ROB_W)
  ) u_rs2_port (
    .rdy           (rdy),
    .query_s       (bus.rs2_S),
    .query_idx     (bus.rs2),
    .busy_vec      (busy_vec),
    .tag_arr       (tag_arr),
    .value_arr     (value_arr),
    .commit_s      (bus.Reg_write_S),
    .commit_rd     (bus.Reg_rd),
    .commit_tag    (bus.Reg_Reorder),
    .commit_result (bus.Reg_result),
    .busy          (bus.rs2_busy),
    .reorder       (bus.rs2_Reorder),
    .value         (bus.rs2_value)
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Bench for regfile_rename: directed scenarios followed by randomized
// traffic, all compared against a register-level reference model.
module tb_regfile_rename;

`ifdef REGFILE_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clr;

  always #5 clk = ~clk;

  regfile_rename_if bus ();

  regfile_rename dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what each architectural register holds and who owns it.
  logic [31:0] m_value [32];
  logic        m_busy  [32];
  logic [3:0]  m_tag   [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_value[i] = '0;
      m_busy[i]  = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_step();
    int rd;
    if (!rdy) return;
    if (bus.Reg_write_S && bus.Reg_rd != 0) begin
      rd = int'(bus.Reg_rd);
      m_value[rd] = bus.Reg_result;
      if (m_busy[rd] && m_tag[rd] == bus.Reg_Reorder) m_busy[rd] = 1'b0;
    end
    if (clr) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (bus.Dispatch_S && bus.Dispatch_rd != 0) begin
      rd = int'(bus.Dispatch_rd);
      m_busy[rd] = 1'b1;
      m_tag[rd]  = bus.Dispatch_Reorder;
    end
  endtask

  // Compare both query ports against what the model says right now.
  task automatic check_ports(input string ctx);
    logic        s, fwd, eb;
    logic [4:0]  idx;
    logic [3:0]  et;
    logic [31:0] ev;
    for (int p = 0; p < 2; p++) begin
      s   = (p == 0) ? bus.rs1_S : bus.rs2_S;
      idx = (p == 0) ? bus.rs1 : bus.rs2;
      fwd = BYP && rdy && bus.Reg_write_S && bus.Reg_rd == idx && idx != 0 &&
            m_busy[idx] && m_tag[idx] == bus.Reg_Reorder;
      eb  = s && idx != 0 && m_busy[idx] && !fwd;
      et  = s ? m_tag[idx] : 4'h0;
      ev  = (!s || idx == 0) ? 32'h0 : (fwd ? bus.Reg_result : m_value[idx]);
      if (p == 0) begin
        check_eq({ctx, ".rs1_busy"}, {31'b0, bus.rs1_busy}, {31'b0, eb});
        check_eq({ctx, ".rs1_tag"},  {28'b0, bus.rs1_Reorder}, {28'b0, et});
        check_eq({ctx, ".rs1_value"}, bus.rs1_value, ev);
      end else begin
        check_eq({ctx, ".rs2_busy"}, {31'b0, bus.rs2_busy}, {31'b0, eb});
        check_eq({ctx, ".rs2_tag"},  {28'b0, bus.rs2_Reorder}, {28'b0, et});
        check_eq({ctx, ".rs2_value"}, bus.rs2_value, ev);
      end
    end
  endtask

  task automatic set_idle();
    rdy = 1'b1;
    clr = 1'b0;
    bus.rs1_S = 1'b0; bus.rs1 = '0;
    bus.rs2_S = 1'b0; bus.rs2 = '0;
    bus.Dispatch_S = 1'b0; bus.Dispatch_rd = '0; bus.Dispatch_Reorder = '0;
    bus.Reg_write_S = 1'b0; bus.Reg_rd = '0; bus.Reg_Reorder = '0; bus.Reg_result = '0;
  endtask

  // Inputs are already applied (at posedge+1); check, clock, update model.
  task automatic step(input string ctx);
    #2;
    check_ports(ctx);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic query(input logic [4:0] a, input logic [4:0] b);
    bus.rs1_S = 1'b1; bus.rs1 = a;
    bus.rs2_S = 1'b1; bus.rs2 = b;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] t);
    bus.Dispatch_S = 1'b1; bus.Dispatch_rd = rd; bus.Dispatch_Reorder = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
    bus.Reg_write_S = 1'b1; bus.Reg_rd = rd; bus.Reg_Reorder = t; bus.Reg_result = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, observed while rst is still asserted.
    query(5'd5, 5'd0);
    #2;
    check_eq("reset.busy",  {31'b0, bus.rs1_busy}, 32'd0);
    check_eq("reset.tag",   {28'b0, bus.rs1_Reorder}, 32'd0);
    check_eq("reset.value", bus.rs1_value, 32'd0);
    $display("txn reset: x5 busy=%0d tag=%0d value=0x%0h", bus.rs1_busy, bus.rs1_Reorder, bus.rs1_value);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Rename x5 -> tag 3, then observe it.
    set_idle(); rename(5'd5, 4'd3); step("ren_x5");
    set_idle(); query(5'd5, 5'd5);
    #2;
    check_eq("x5_renamed.busy", {31'b0, bus.rs1_busy}, 32'd1);
    check_eq("x5_renamed.tag",  {28'b0, bus.rs1_Reorder}, 32'd3);
    $display("txn rename x5 tag3: busy=%0d tag=%0d", bus.rs1_busy, bus.rs1_Reorder);
    step("q_x5");

    // Commit x5/tag 3 while querying x5 in the same cycle.
    set_idle(); query(5'd5, 5'd0); commit(5'd5, 4'd3, 32'hDEAD);
    #2;
    check_eq("x5_commit_cycle.busy", {31'b0, bus.rs1_busy}, BYP ? 32'd0 : 32'd1);
    check_eq("x5_commit_cycle.value", bus.rs1_value, BYP ? 32'hDEAD : 32'h0);
    $display("txn commit x5 tag3 0xdead: same-cycle busy=%0d value=0x%0h", bus.rs1_busy, bus.rs1_value);
    step("commit_x5");
    set_idle(); query(5'd5, 5'd0);
    #2;
    check_eq("x5_after.busy",  {31'b0, bus.rs1_busy}, 32'd0);
    check_eq("x5_after.value", bus.rs1_value, 32'hDEAD);
    step("q_x5_after");

    // Older commit must not retire a younger rename.
    set_idle(); rename(5'd7, 4'd2); step("ren_x7_t2");
    set_idle(); rename(5'd7, 4'd6); step("ren_x7_t6");
    set_idle(); commit(5'd7, 4'd2, 32'h11); step("commit_x7_t2");
    set_idle(); query(5'd7, 5'd7);
    #2;
    check_eq("x7_young.busy",  {31'b0, bus.rs1_busy}, 32'd1);
    check_eq("x7_young.tag",   {28'b0, bus.rs1_Reorder}, 32'd6);
    check_eq("x7_young.value", bus.rs1_value, 32'h11);
    $display("txn x7 stale commit: busy=%0d tag=%0d value=0x%0h", bus.rs1_busy, bus.rs1_Reorder, bus.rs1_value);
    step("q_x7");

    // Same-cycle rename and commit of x9: rename wins, value still written.
    set_idle(); rename(5'd9, 4'd4); commit(5'd9, 4'd1, 32'h22); step("ren_commit_x9");
    set_idle(); query(5'd9, 5'd0);
    #2;
    check_eq("x9_both.busy",  {31'b0, bus.rs1_busy}, 32'd1);
    check_eq("x9_both.tag",   {28'b0, bus.rs1_Reorder}, 32'd4);
    check_eq("x9_both.value", bus.rs1_value, 32'h22);
    $display("txn x9 rename+commit: busy=%0d tag=%0d value=0x%0h", bus.rs1_busy, bus.rs1_Reorder, bus.rs1_value);
    step("q_x9");

    // Flush with a concurrent commit and rename.
    set_idle(); rename(5'd1, 4'd7); step("ren_x1");
    set_idle(); rename(5'd2, 4'd8); step("ren_x2");
    set_idle(); rename(5'd3, 4'd9); step("ren_x3");
    set_idle(); clr = 1'b1; commit(5'd1, 4'd12, 32'h55); rename(5'd4, 4'd5); step("clr");
    set_idle(); query(5'd1, 5'd4);
    #2;
    check_eq("clr.x1_busy",  {31'b0, bus.rs1_busy}, 32'd0);
    check_eq("clr.x1_value", bus.rs1_value, 32'h55);
    check_eq("clr.x4_busy",  {31'b0, bus.rs2_busy}, 32'd0);
    $display("txn clr: x1 busy=%0d value=0x%0h x4 busy=%0d", bus.rs1_busy, bus.rs1_value, bus.rs2_busy);
    step("q_clr");
    set_idle(); query(5'd2, 5'd3); step("q_clr_x2x3");

    // rdy low freezes state.
    set_idle(); rdy = 1'b0; rename(5'd10, 4'd8); commit(5'd5, 4'd0, 32'hBAD); step("rdy_low");
    set_idle(); query(5'd10, 5'd5);
    #2;
    check_eq("rdy_low.x10_busy", {31'b0, bus.rs1_busy}, 32'd0);
    check_eq("rdy_low.x5_value", bus.rs2_value, 32'hDEAD);
    step("q_rdy_low");

    // x0 ignores rename and commit.
    set_idle(); rename(5'd0, 4'd3); commit(5'd0, 4'd3, 32'hFFFF); step("x0_write");
    set_idle(); query(5'd0, 5'd0);
    #2;
    check_eq("x0.busy",  {31'b0, bus.rs1_busy}, 32'd0);
    check_eq("x0.value", bus.rs1_value, 32'd0);
    step("q_x0");

    // Asynchronous reset mid-operation.
    set_idle(); rename(5'd12, 4'd9); step("ren_x12");
    set_idle(); query(5'd12, 5'd9);
    rst = 1'b1;
    #1;
    check_eq("async_rst.busy", {31'b0, bus.rs1_busy}, 32'd0);
    check_eq("async_rst.tag",  {28'b0, bus.rs1_Reorder}, 32'd0);
    check_eq("async_rst.x9_value", bus.rs2_value, 32'd0);
    $display("txn async reset: x12 busy=%0d x9 value=0x%0h", bus.rs1_busy, bus.rs2_value);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic [4:0] rd;
      set_idle();
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1) rename(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        rd = 5'($urandom_range(0, 31));
        commit(rd, ($urandom_range(0, 2) != 0) ? m_tag[rd] : 4'($urandom_range(0, 15)), $urandom);
      end
      bus.rs1_S = ($urandom_range(0, 4) != 0);
      bus.rs1   = ($urandom_range(0, 1) == 1) ? bus.Reg_rd : 5'($urandom_range(0, 31));
      bus.rs2_S = ($urandom_range(0, 4) != 0);
      bus.rs2   = 5'($urandom_range(0, 31));
      $display("txn rnd %0d: rdy=%0d clr=%0d ren=%0d x%0d t%0d com=%0d x%0d t%0d q x%0d x%0d",
               c, rdy, clr, bus.Dispatch_S, bus.Dispatch_rd, bus.Dispatch_Reorder,
               bus.Reg_write_S, bus.Reg_rd, bus.Reg_Reorder, bus.rs1, bus.rs2);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
